// File: rtl/circuito_sweep_pkg.sv
// -----------------------------------------------------------------------------
// circuito_sweep_pkg
//   Shared types and sizing constants for the truth-table sweep controller.
//   - state_t : sweep FSM states
//   - N_VEC   : number of input vectors (4 inputs -> 16 combinations)
//   - IDX_W   : width of the vector index {a,b,c,d}
//   - CNT_W   : width of the ones counter (0..16 needs 5 bits)
// -----------------------------------------------------------------------------
package circuito_sweep_pkg;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage : circuito_sweep_pkg

// File: rtl/circuito_sweep_ctrl_settle_timer.sv
// -----------------------------------------------------------------------------
// sweep_settle_timer
//   Down-counter that measures how long each vector is held in SETTLE.
//   Parameter SETTLE_CYCLES (>= 1): number of SETTLE cycles per vector.
//   Ports:
//     clk     in  : clock, rising edge
//     rst     in  : synchronous active-high reset
//     load    in  : reload the counter (asserted on the edge entering SETTLE)
//     en      in  : high while the FSM sits in SETTLE
//     expired out : high during the last SETTLE cycle
// -----------------------------------------------------------------------------
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  // Counter holds "remaining SETTLE cycles after this one", so it never
  // needs to represent SETTLE_CYCLES itself.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: default assignment first so every path through the block drives
  // cnt_d; a missing branch would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule : sweep_settle_timer

// File: rtl/circuito_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// circuito_sweep_ctrl
//   Steps a 4-input combinational circuit through all 16 input vectors in
//   order, holds each for SETTLE_CYCLES cycles, samples s1 in a dedicated
//   SAMPLE cycle, and builds a 16-bit truth table plus its ones count.
//
//   Optional feature (macro SWEEP_COMPARE_EN): compares each sample against
//   a golden table and reports a sticky mismatch with the first failing idx.
//
//   Ports:
//     clk            in      clock, rising edge
//     rst            in      synchronous active-high reset
//     start          in      sweep request, honoured only in IDLE
//     dut_a..dut_d   out     circuit inputs, idx bits 3..0
//     dut_s1         in      circuit output
//     busy           out     high during SETTLE/SAMPLE
//     done           out     one-cycle pulse in DONE
//     table_out      out[16] bit k = s1 sampled at idx k
//     ones_count     out[5]  population count of table_out
//   SWEEP_COMPARE_EN only:
//     expected       in[16]  golden truth table
//     mismatch       out     sticky compare failure
//     first_fail_idx out[4]  idx of first failure (0 if none)
// -----------------------------------------------------------------------------
module circuito_sweep_ctrl
  import circuito_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  output logic             dut_d,
  input  logic             dut_s1,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic [CNT_W-1:0] ones_count
`ifdef SWEEP_COMPARE_EN
  ,
  input  logic [N_VEC-1:0] expected,
  output logic             mismatch,
  output logic [IDX_W-1:0] first_fail_idx
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_VEC-1:0]   table_q, table_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timer_load;
  logic               timer_expired;

`ifdef SWEEP_COMPARE_EN
  logic               mismatch_q, mismatch_d;
  logic [IDX_W-1:0]   first_fail_q, first_fail_d;
`endif

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (state_q == SETTLE),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    table_d    = table_q;
    ones_d     = ones_q;
    timer_load = 1'b0;
`ifdef SWEEP_COMPARE_EN
    mismatch_d   = mismatch_q;
    first_fail_d = first_fail_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          idx_d      = '0;
          table_d    = '0;
          ones_d     = '0;
          timer_load = 1'b1;
`ifdef SWEEP_COMPARE_EN
          mismatch_d   = 1'b0;
          first_fail_d = '0;
`endif
        end
      end

      SETTLE: begin
        if (timer_expired) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        table_d[idx_q] = dut_s1;
        ones_d         = ones_q + CNT_W'(dut_s1);
`ifdef SWEEP_COMPARE_EN
        // Only the first failure is recorded; later ones leave the index alone.
        if ((dut_s1 != expected[idx_q]) && !mismatch_q) begin
          mismatch_d   = 1'b1;
          first_fail_d = idx_q;
        end
`endif
        if (idx_q == LAST_IDX) begin
          // idx stays at 15 so the circuit keeps seeing 1111 after the sweep.
          state_d = DONE;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          state_d    = SETTLE;
          timer_load = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SWEEP_COMPARE_EN
      mismatch_q   <= 1'b0;
      first_fail_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SWEEP_COMPARE_EN
      mismatch_q   <= mismatch_d;
      first_fail_q <= first_fail_d;
`endif
    end
  end

  assign dut_a      = idx_q[3];
  assign dut_b      = idx_q[2];
  assign dut_c      = idx_q[1];
  assign dut_d      = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign ones_count = ones_q;

`ifdef SWEEP_COMPARE_EN
  assign mismatch       = mismatch_q;
  assign first_fail_idx = first_fail_q;
`endif

endmodule : circuito_sweep_ctrl

// File: tb/tb_circuito_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_circuito_sweep_ctrl
//   Directed bench for circuito_sweep_ctrl. Two instances: u_dut1 with
//   SETTLE_CYCLES=1 and u_dut3 with SETTLE_CYCLES=3. A behavioural stub per
//   instance plays the combinational circuit (parity, AND or constant 0).
//   Cycle n is the interval following clock edge n; start is sampled at edge 0.
// -----------------------------------------------------------------------------
module tb_circuito_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic        a1, b1, c1, d1, s1_1;
  logic        a3, b3, c3, d3, s1_3;
  logic        busy1, done1, busy3, done3;
  logic [15:0] table1, table3;
  logic [4:0]  ones1, ones3;
  int          stub_mode;  // 0 parity, 1 AND, 2 constant 0

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SWEEP_COMPARE_EN
  logic [15:0] exp1, exp3;
  logic        mm1, mm3;
  logic [3:0]  ff1, ff3;
`endif

  always #5 clk = ~clk;

  function automatic logic stub(input int mode, input logic a, b, c, d);
    case (mode)
      0:       return a ^ b ^ c ^ d;
      1:       return a & b & c & d;
      default: return 1'b0;
    endcase
  endfunction

  assign s1_1 = stub(stub_mode, a1, b1, c1, d1);
  assign s1_3 = stub(stub_mode, a3, b3, c3, d3);

  circuito_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk (clk), .rst (rst), .start (start1),
    .dut_a (a1), .dut_b (b1), .dut_c (c1), .dut_d (d1), .dut_s1 (s1_1),
    .busy (busy1), .done (done1), .table_out (table1), .ones_count (ones1)
`ifdef SWEEP_COMPARE_EN
    , .expected (exp1), .mismatch (mm1), .first_fail_idx (ff1)
`endif
  );

  circuito_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk (clk), .rst (rst), .start (start3),
    .dut_a (a3), .dut_b (b3), .dut_c (c3), .dut_d (d3), .dut_s1 (s1_3),
    .busy (busy3), .done (done3), .table_out (table3), .ones_count (ones3)
`ifdef SWEEP_COMPARE_EN
    , .expected (exp3), .mismatch (mm3), .first_fail_idx (ff3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs and samples sit 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on u_dut1 from IDLE; ends in cycle 37 (IDLE).
  task automatic sweep1(input string tag);
    int bad_busy = 0;
    int done_cnt = 0;
    int done_at  = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      if (busy1 !== (cyc <= 32)) bad_busy++;
      if (done1 === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      step();
    end
    check({tag, "_busy_window_errs"}, bad_busy, 0);
    check({tag, "_done_cycle"}, done_at, 33);
    check({tag, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    int bad;
    int bad_busy;
    int first_done;
    int last_done;
    int done_at;

    rst       = 1'b1;
    start1    = 1'b0;
    start3    = 1'b0;
    stub_mode = 0;
`ifdef SWEEP_COMPARE_EN
    exp1 = 16'h6996;
    exp3 = 16'h6996;
`endif
    step();
    step();

    // Reset state
    check("rst_busy",  busy1, 0);
    check("rst_done",  done1, 0);
    check("rst_table", table1, 16'h0000);
    check("rst_ones",  ones1, 0);
    check("rst_abcd",  {a1, b1, c1, d1}, 4'b0000);
    check("rst_busy3", busy3, 0);
    rst = 1'b0;
    step();

    // Parity stub, SETTLE_CYCLES=1
    stub_mode = 0;
    sweep1("parity");
    check("parity_table", table1, 16'h6996);
    check("parity_ones",  ones1, 8);
    check("parity_abcd_after", {a1, b1, c1, d1}, 4'b1111);
    check("parity_busy_idle",  busy1, 0);

    // AND stub
    stub_mode = 1;
    sweep1("and");
    check("and_table", table1, 16'h8000);
    check("and_ones",  ones1, 1);

    // Constant-0 stub
    stub_mode = 2;
    sweep1("zero");
    check("zero_table", table1, 16'h0000);
    check("zero_ones",  ones1, 0);

    // Vector order with SETTLE_CYCLES=3: each vector held 4 cycles
    stub_mode = 0;
    bad = 0;
    bad_busy = 0;
    done_at = 0;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int cyc = 1; cyc <= 68; cyc++) begin
      if (cyc <= 64 && {a3, b3, c3, d3} !== 4'((cyc - 1) / 4)) bad++;
      if (busy3 !== (cyc <= 64)) bad_busy++;
      if (done3 === 1'b1) done_at = cyc;
      step();
    end
    check("s3_vector_order_errs", bad, 0);
    check("s3_busy_window_errs",  bad_busy, 0);
    check("s3_done_cycle", done_at, 65);
    check("s3_table", table3, 16'h6996);
    check("s3_ones",  ones3, 8);

    // Reset during cycle 10 of a sweep
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) step();
    check("pre_rst_table", table1, 16'h0006);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy",  busy1, 0);
    check("abort_abcd",  {a1, b1, c1, d1}, 4'b0000);
    check("abort_table", table1, 16'h0000);
    check("abort_ones",  ones1, 0);
    check("abort_table3", table3, 16'h0000);
    step();
    check("abort_stays_idle", busy1, 0);
    sweep1("post_rst");
    check("post_rst_table", table1, 16'h6996);
    check("post_rst_ones",  ones1, 8);

    // Start pulsed mid-sweep, then held high through DONE
    bad_busy   = 0;
    first_done = 0;
    last_done  = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (busy1 !== ((cyc <= 32) || (cyc >= 35 && cyc <= 66))) bad_busy++;
      if (done1 === 1'b1) begin
        if (first_done == 0) first_done = cyc;
        last_done = cyc;
      end
      if (cyc == 34) check("hold_idle_table", table1, 16'h6996);
      if (cyc == 35) begin
        check("hold_restart_table", table1, 16'h0000);
        check("hold_restart_ones",  ones1, 0);
      end
      if (cyc == 5 || cyc == 20 || cyc == 30) start1 = 1'b1;
      if (cyc == 6 || cyc == 21 || cyc == 35) start1 = 1'b0;
      step();
    end
    check("hold_busy_window_errs", bad_busy, 0);
    check("hold_first_done", first_done, 33);
    check("hold_second_done", last_done, 67);
    check("hold_final_table", table1, 16'h6996);

`ifdef SWEEP_COMPARE_EN
    // Compare feature
    exp1 = 16'h6997;
    sweep1("cmp_bad0");
    check("cmp_bad0_mismatch", mm1, 1);
    check("cmp_bad0_first",    ff1, 0);

    exp1 = 16'h7996;
    sweep1("cmp_bad12");
    check("cmp_bad12_mismatch", mm1, 1);
    check("cmp_bad12_first",    ff1, 12);

    exp1 = 16'h6996;
    sweep1("cmp_good");
    check("cmp_good_mismatch", mm1, 0);
    check("cmp_good_first",    ff1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_circuito_sweep_ctrl
